regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with a pending-write scoreboard, successor to the single-read-pair register bank in the RV32I core. It sits between decode/issue and write-back. It provides NRD combinational operand reads with per-port busy flags. It accepts one write-back per cycle under a valid/ready handshake and reports completion one cycle later. Destination allocation at issue is handshaked so that a second producer cannot claim a register still pending a write (WAW guard).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_mp_scoreboard.sv | 58 +++++
 rtl/regfile_mp.sv | 62 ++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Optional same-cycle write-back bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Issue/write-back bus of regfile_mp: operand reads, destination allocation and write-back.
// The master side is decode/issue plus write-back; the slave side is the register file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  logic                alloc_valid;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ready;

  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                wb_ready;
  logic                wb_comp;
  logic [AW-1:0]       wb_comp_addr;
  logic                wb_err;

  modport master (
    output rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_busy, alloc_ready, wb_ready, wb_comp, wb_comp_addr, wb_err
  );

  modport slave (
    input  rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data,
    output rd_data, rd_busy, alloc_ready, wb_ready, wb_comp, wb_comp_addr, wb_err
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, WAW-guarded allocation,
// write-back completion pulse and sticky stray-write-back error.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic            wb_comp,
  output logic [AW-1:0]   wb_comp_addr,
  output logic            wb_err,
  output logic [NREG-1:0] busy
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            alloc_fire;
  logic            wb_stray;

  // A write-back landing this cycle frees the register, so a new producer may claim it.
  assign alloc_ready = !busy_q[alloc_addr] || (wb_valid && wb_addr == alloc_addr);
  assign alloc_fire  = alloc_valid && alloc_ready && alloc_addr != ZERO_IDX;
  assign wb_stray    = wb_valid && wb_addr != ZERO_IDX && !busy_q[wb_addr];
  assign busy        = busy_q;

  // NOTE: every always_comb output gets a full default first, so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)   busy_d[wb_addr]    = 1'b0;
    if (alloc_fire) busy_d[alloc_addr] = 1'b1;  // set after clear: the new producer wins
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      wb_comp      <= 1'b0;
      wb_comp_addr <= '0;
      wb_err       <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      wb_comp <= wb_valid;
      if (wb_valid) wb_comp_addr <= wb_addr;
      if (wb_stray) wb_err       <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic      clk,
  input  logic      rst,
  regfile_mp_if.slave bus
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  reg_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (bus.alloc_valid),
    .alloc_addr   (bus.alloc_addr),
    .alloc_ready  (bus.alloc_ready),
    .wb_valid     (bus.wb_valid),
    .wb_addr      (bus.wb_addr),
    .wb_comp      (bus.wb_comp),
    .wb_comp_addr (bus.wb_comp_addr),
    .wb_err       (bus.wb_err),
    .busy         (busy)
  );

  assign bus.wb_ready = 1'b1;

  // NOTE: the array is reset explicitly because a reset must leave every register reading 0;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_valid && bus.wb_addr != ZERO_IDX) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = bus.rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit = bus.wb_valid && bus.wb_addr == addr && addr != ZERO_IDX;
`else
    assign hit = 1'b0;
`endif
    // x0 is never written, so its stored value is the constant 0.
    assign bus.rd_data[k*XLEN +: XLEN] = hit ? bus.wb_data : regs[addr];
    assign bus.rd_busy[k]              = hit ? 1'b0 : busy[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against a behavioural model of registers, pending flags and completion/error status.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = $clog2(NREG);

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  xdata_t   m_regs [NREG];
  bit       m_busy [NREG];
  bit       m_comp;
  reg_idx_t m_comp_addr;
  bit       m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_comp      = 1'b0;
    m_comp_addr = '0;
    m_err       = 1'b0;
  endfunction

  function automatic bit exp_alloc_ready();
    return !m_busy[bus.alloc_addr] || (bus.wb_valid && bus.wb_addr == bus.alloc_addr);
  endfunction

  function automatic bit same_cycle_hit(input reg_idx_t a);
`ifdef REGFILE_BYPASS_EN
    return bus.wb_valid && bus.wb_addr == a && a != REG_ZERO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic xdata_t exp_data(input reg_idx_t a);
    if (same_cycle_hit(a)) return bus.wb_data;
    return (a == REG_ZERO) ? '0 : m_regs[a];
  endfunction

  function automatic bit exp_busy(input reg_idx_t a);
    if (same_cycle_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    bit       ar, stray;
    reg_idx_t aa, wa;
    if (rst) begin
      model_reset();
      return;
    end
    aa    = bus.alloc_addr;
    wa    = bus.wb_addr;
    ar    = exp_alloc_ready();
    stray = bus.wb_valid && wa != REG_ZERO && !m_busy[wa];
    if (bus.wb_valid) begin
      if (wa != REG_ZERO) m_regs[wa] = bus.wb_data;
      m_busy[wa]  = 1'b0;
      m_comp_addr = wa;
    end
    if (bus.alloc_valid && ar && aa != REG_ZERO) m_busy[aa] = 1'b1;
    m_comp = bus.wb_valid;
    if (stray) m_err = 1'b1;
  endfunction

  task automatic set_in(input bit av, input int aa, input bit wv, input int wa,
                        input xdata_t wd, input int r0, input int r1, input bit r = 1'b0);
    bus.alloc_valid = av;
    bus.alloc_addr  = reg_idx_t'(aa);
    bus.wb_valid    = wv;
    bus.wb_addr     = reg_idx_t'(wa);
    bus.wb_data     = wd;
    bus.rd_addr     = {reg_idx_t'(r1), reg_idx_t'(r0)};
    rst             = r;
  endtask

  // Compare every output against the model, then clock once. Entered 1 time unit after a rising edge.
  task automatic run_cycle();
    reg_idx_t a;
    #2;
    for (int k = 0; k < NRD; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      check($sformatf("rd_data%0d[x%0d]", k, a), 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(exp_data(a)));
      check($sformatf("rd_busy%0d[x%0d]", k, a), 64'(bus.rd_busy[k]), 64'(exp_busy(a)));
    end
    check("alloc_ready", 64'(bus.alloc_ready), 64'(exp_alloc_ready()));
    check("wb_ready", 64'(bus.wb_ready), 64'(1));
    check("wb_comp", 64'(bus.wb_comp), 64'(m_comp));
    if (m_comp) check("wb_comp_addr", 64'(bus.wb_comp_addr), 64'(m_comp_addr));
    check("wb_err", 64'(bus.wb_err), 64'(m_err));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, '0, 0, 0, 1'b1);
    @(posedge clk);
    model_reset();
    #1;

    // Reset state: every register reads 0 and is idle
    for (int i = 0; i < NREG; i += 2) begin
      set_in(0, 0, 0, 0, '0, i, i + 1);
      run_cycle();
    end

    // Basic allocate / write-back / complete
    set_in(1, 5, 0, 0, '0, 5, 0);
    #2 check("alloc_ready_x5", 64'(bus.alloc_ready), 64'(1));
    run_cycle();
    set_in(0, 0, 0, 0, '0, 5, 0);
    #2 check("busy_x5_set", 64'(bus.rd_busy[0]), 64'(1));
    run_cycle();
    set_in(0, 0, 1, 5, 32'hDEAD_BEEF, 5, 0);
    run_cycle();
    set_in(0, 0, 0, 0, '0, 5, 0);
    #2;
    check("data_x5", 64'(bus.rd_data[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
    check("busy_x5_clear", 64'(bus.rd_busy[0]), 64'(0));
    check("comp_x5", 64'(bus.wb_comp), 64'(1));
    check("comp_addr_x5", 64'(bus.wb_comp_addr), 64'(5));
    run_cycle();

    // x0 guard
    set_in(1, 0, 0, 0, '0, 0, 0);
    run_cycle();
    set_in(0, 0, 1, 0, 32'h1234_5678, 0, 0);
    #2 check("busy_x0_never", 64'(bus.rd_busy[0]), 64'(0));
    run_cycle();
    set_in(0, 0, 0, 0, '0, 0, 0);
    #2;
    check("data_x0", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
    check("comp_x0", 64'(bus.wb_comp), 64'(1));
    check("err_x0", 64'(bus.wb_err), 64'(0));
    run_cycle();

    // WAW guard and same-cycle write-back + allocation
    set_in(1, 7, 0, 0, '0, 0, 7);
    run_cycle();
    set_in(1, 7, 0, 0, '0, 0, 7);
    #2 check("waw_block_x7", 64'(bus.alloc_ready), 64'(0));
    run_cycle();
    set_in(1, 7, 1, 7, 32'h1111_2222, 0, 7);
    #2 check("waw_overlap_x7", 64'(bus.alloc_ready), 64'(1));
    run_cycle();
    set_in(0, 0, 0, 0, '0, 0, 7);
    #2;
    check("data_x7", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'h0000_0000_1111_2222);
    check("busy_x7_kept", 64'(bus.rd_busy[1]), 64'(1));
    run_cycle();
    set_in(0, 0, 1, 7, 32'h3333_4444, 0, 7);
    run_cycle();

    // Same-cycle write-back and read of x9
    set_in(1, 9, 0, 0, '0, 0, 9);
    run_cycle();
    set_in(0, 0, 1, 9, 32'hA5A5_A5A5, 0, 9);
    #2;
`ifdef REGFILE_BYPASS_EN
    check("bypass_data_x9", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'h0000_0000_A5A5_A5A5);
    check("bypass_busy_x9", 64'(bus.rd_busy[1]), 64'(0));
`else
    check("nobypass_data_x9", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'(0));
    check("nobypass_busy_x9", 64'(bus.rd_busy[1]), 64'(1));
`endif
    run_cycle();
    set_in(0, 0, 0, 0, '0, 0, 9);
    #2;
    check("data_x9_next", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'h0000_0000_A5A5_A5A5);
    check("busy_x9_next", 64'(bus.rd_busy[1]), 64'(0));
    run_cycle();

    // Stray write-back sets a sticky error
    set_in(0, 0, 1, 3, 32'h0BAD_0003, 3, 0);
    run_cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, '0, 3, 0);
      run_cycle();
    end
    set_in(0, 0, 0, 0, '0, 3, 0);
    #2 check("err_sticky", 64'(bus.wb_err), 64'(1));
    run_cycle();

    // Reset on the same edge as a write-back discards it
    set_in(1, 4, 0, 0, '0, 4, 0);
    run_cycle();
    set_in(0, 0, 1, 4, 32'hCAFE_F00D, 4, 0, 1'b1);
    run_cycle();
    set_in(0, 0, 0, 0, '0, 4, 3);
    #2;
    check("rst_data_x4", 64'(bus.rd_data[XLEN-1:0]), 64'(0));
    check("rst_data_x3", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'(0));
    check("rst_comp", 64'(bus.wb_comp), 64'(0));
    check("rst_err", 64'(bus.wb_err), 64'(0));
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'(1));
    run_cycle();

    // Randomized traffic, biased to a few registers so collisions are frequent
    for (int n = 0; n < 3000; n++) begin
      int aa, wa, r0, r1;
      aa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 7);
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 7);
      r0 = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, 7);
      r1 = $urandom_range(0, NREG - 1);
      set_in(1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), wa, xdata_t'($urandom()),
             r0, r1, $urandom_range(0, 199) == 0);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
